// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_ready;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from imem, presents one instruction at a time.
// Optional misaligned-target fault enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_if.master                imem,
  input  logic                   PCsrc,
  input  logic [ADDR_WIDTH-1:0]  ImmOp,
  input  logic                   stall,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_valid,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic                   fetch_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
`ifdef FETCH_MISALIGN_CHECK_EN
    VALID,
    FAULT
`else
    VALID
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_pc;

  assign next_pc = PCsrc ? PC + ImmOp : PC + ADDR_WIDTH'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    imem.imem_req  = 1'b0;
    imem.imem_addr = PC;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ready) state_d = VALID;
      end
      VALID: begin
        if (!stall) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) state_d = FAULT;
          else                       state_d = REQ;
`else
          state_d = REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      FAULT: state_d = FAULT;
`endif
      default: state_d = IDLE;
    endcase
  end

  // The PC advances on leaving VALID whether the target is fetched or faults,
  // so a faulting address stays visible on PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
          if (imem.imem_ready) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
          end
        end
        VALID: begin
          if (!stall) begin
            PC          <= next_pc;
            instr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = (state_q == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level model of the fetch handshake,
// directed scenarios followed by randomized ready/stall/branch traffic.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst_n;
  logic        PCsrc;
  logic [31:0] ImmOp;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC;
  logic        fetch_fault;

  int unsigned n_checks;
  int unsigned n_fail;

  // Model: which phase of the instruction's life we are in, plus architectural PC.
  logic        m_boot;
  logic        m_fetch;
  logic        m_valid;
  logic        m_fault;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  fetch_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_unit #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (bus),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp),
    .stall      (stall),
    .instr      (instr),
    .instr_valid(instr_valid),
    .PC         (PC),
    .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    rst_n          = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    stall          = 1'b0;
    PCsrc          = 1'b0;
    ImmOp          = '0;
    m_boot  = 1'b1;
    m_fetch = 1'b0;
    m_valid = 1'b0;
    m_fault = 1'b0;
    m_pc    = RST_PC;
    m_instr = '0;
    #1;
    check_eq("rst_pc",    PC,           RST_PC);
    check_eq("rst_req",   bus.imem_req, 32'd0);
    check_eq("rst_valid", instr_valid,  32'd0);
    check_eq("rst_instr", instr,        32'd0);
    check_eq("rst_fault", fetch_fault,  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Check the present outputs against the model, drive one cycle of inputs, advance the model.
  task automatic cycle(input logic rdy, input logic stl, input logic src, input logic [31:0] imm);
    logic [31:0] data;
    check_eq("req",   bus.imem_req, m_fetch);
    check_eq("valid", instr_valid,  m_valid);
    check_eq("pc",    PC,           m_pc);
    check_eq("instr", instr,        m_instr);
    check_eq("fault", fetch_fault,  m_fault);
    if (m_fetch) check_eq("addr", bus.imem_addr, m_pc);
    data           = $urandom;
    bus.imem_ready = rdy;
    bus.imem_rdata = data;
    stall          = stl;
    PCsrc          = src;
    ImmOp          = imm;
    if (m_boot) begin
      m_boot  = 1'b0;
      m_fetch = 1'b1;
    end else if (m_fetch && rdy) begin
      m_fetch = 1'b0;
      m_valid = 1'b1;
      m_instr = data;
    end else if (m_valid && !stl) begin
      m_valid = 1'b0;
      m_pc    = src ? m_pc + imm : m_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (m_pc[1:0] != 2'b00) m_fault = 1'b1;
      else                    m_fetch = 1'b1;
`else
      m_fetch = 1'b1;
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic to_valid();
    int unsigned n = 0;
    while (!m_valid && n < 20) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      n++;
    end
    check_eq("to_valid_timeout", instr_valid, 32'd1);
  endtask

  task automatic to_fetch();
    int unsigned n = 0;
    while (!m_fetch && n < 20) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd0);
      n++;
    end
    check_eq("to_fetch_timeout", bus.imem_req, 32'd1);
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] imm;
    logic        rdy, stl, src;
    n_checks = 0;
    n_fail   = 0;
    @(negedge clk);
    apply_reset();

    // Back-to-back sequential fetches with imem always ready
    for (int k = 0; k < 3; k++) begin
      to_fetch();
      check_eq("t1_addr", bus.imem_addr, RST_PC + 32'(4 * k));
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      check_eq("t1_valid", instr_valid, 32'd1);
    end

    // imem slow to respond: request held with stable address
    to_fetch();
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t2_req", bus.imem_req, 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("t2_valid", instr_valid, 32'd1);

    // Downstream stall holds the presented instruction
    p = m_pc;
    repeat (4) cycle(1'b1, 1'b1, 1'b1, 32'h40);
    check_eq("t3_valid", instr_valid, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t3_addr", bus.imem_addr, p + 32'd4);

    // Backward branch from 0xBFC00010
    to_valid();
    cycle(1'b0, 1'b0, 1'b1, 32'hBFC0_0010 - m_pc);
    to_valid();
    check_eq("t4_pc", PC, 32'hBFC0_0010);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    check_eq("t4_addr", bus.imem_addr, 32'hBFC0_0008);

    // PC wraps from the top of the address space
    to_valid();
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC - m_pc);
    to_valid();
    cycle(1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("t5_addr", bus.imem_addr, 32'h0000_0000);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("t5_valid", instr_valid, 32'd1);

    // Misaligned branch target
    p = m_pc;
    cycle(1'b0, 1'b0, 1'b1, 32'd2);
`ifdef FETCH_MISALIGN_CHECK_EN
    check_eq("t6_fault", fetch_fault, 32'd1);
    check_eq("t6_req", bus.imem_req, 32'd0);
    check_eq("t6_pc", PC, p + 32'd2);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("t6_sticky", fetch_fault, 32'd1);
`else
    check_eq("t6_addr", bus.imem_addr, p + 32'd2);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("t6_valid", instr_valid, 32'd1);
`endif

    // Random traffic, with one reset landing mid-stream
    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      rdy = ($urandom_range(0, 3) != 0);
      stl = ($urandom_range(0, 3) == 0);
      src = 1'($urandom_range(0, 1));
      imm = $urandom;
      imm[1:0] = 2'b00;
`ifndef FETCH_MISALIGN_CHECK_EN
      if ($urandom_range(0, 15) == 0) imm[1] = 1'b1;
`endif
      cycle(rdy, stl, src, imm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
